// File: rtl/string_match_pkg.sv
// Shared byte type, pattern-slot record and ASCII case folding for the
// multi-pattern string comparator.
package string_match_pkg;

  localparam int unsigned BYTE_W       = 8;
  localparam int unsigned SLOT_MAX_LEN = 17;

  typedef logic [BYTE_W-1:0] byte_t;

  typedef struct packed {
    logic [SLOT_MAX_LEN*BYTE_W-1:0]      str;
    logic [$clog2(SLOT_MAX_LEN+1)-1:0]   len;
  } slot_t;

  function automatic byte_t fold_byte(input byte_t b);
    return (b >= 8'h41 && b <= 8'h5a) ? (b | 8'h20) : b;
  endfunction

endpackage

// File: rtl/pattern_lane.sv
// Combinational compare of one pattern slot against the byte window, testing
// every end offset inside the newest word.
module pattern_lane
  import string_match_pkg::*;
#(
  parameter int unsigned MAX_LEN    = 17,
  parameter int unsigned WORD_BYTES = 4,
  parameter int unsigned LEN_W      = 5,
  parameter int unsigned SEEN_W     = 5
) (
  input  logic [MAX_LEN*BYTE_W-1:0]       i_str,
  input  logic [LEN_W-1:0]                i_len,
  input  byte_t [MAX_LEN+WORD_BYTES-2:0]  i_win,
  input  logic [SEEN_W-1:0]               i_seen,
  input  logic                            i_nocase,
  output logic                            o_hit
);

  byte_t [MAX_LEN-1:0]   w_pat_r;
  logic [WORD_BYTES-1:0] w_off_hit;

  // Pattern re-indexed from its last byte so the window compare uses fixed taps.
  always_comb begin
    w_pat_r = '0;
    for (int unsigned j = 0; j < MAX_LEN; j++) begin
      if (j < 32'(i_len)) begin
        w_pat_r[j] = i_str[(MAX_LEN - 32'(i_len) + j)*BYTE_W +: BYTE_W];
        if (i_nocase) w_pat_r[j] = fold_byte(w_pat_r[j]);
      end
    end
  end

  // Window byte MAX_LEN-1+o is byte o of the newest word.
  always_comb begin
    w_off_hit = '0;
    for (int unsigned o = 0; o < WORD_BYTES; o++) begin
      w_off_hit[o] = (i_len != '0) && (32'(i_seen) + o + 1 >= 32'(i_len));
      for (int unsigned j = 0; j < MAX_LEN; j++) begin
        if (j < 32'(i_len) && i_win[MAX_LEN-1+o-j] != w_pat_r[j]) w_off_hit[o] = 1'b0;
      end
    end
  end

  assign o_hit = |w_off_hit;

endmodule

// File: rtl/multi_string_comparator.sv
// Streaming multi-pattern matcher: byte history, programmable slots, match
// flag registers and a fixed-latency payload delay line.
module multi_string_comparator
  import string_match_pkg::*;
#(
  parameter int unsigned NUM_PATTERNS = 4,
  parameter int unsigned MAX_LEN      = 17,
  parameter int unsigned WORD_BYTES   = 4,
  parameter int unsigned OUT_DELAY    = 6
) (
  input  logic                              clk,
  input  logic                              n_rst,
  input  logic                              clear,
  input  logic                              nocase,
  input  logic                              pat_wr_en,
  input  logic [$clog2(NUM_PATTERNS)-1:0]   pat_wr_idx,
  input  logic [MAX_LEN*BYTE_W-1:0]         pat_wr_str,
  input  logic [$clog2(MAX_LEN+1)-1:0]      pat_wr_len,
  input  logic                              data_valid,
  input  logic [WORD_BYTES*BYTE_W-1:0]      data_in,
  output logic [WORD_BYTES*BYTE_W-1:0]      data_out,
  output logic                              data_out_valid,
  output logic                              match,
  output logic [NUM_PATTERNS-1:0]           match_vec,
  output logic [$clog2(NUM_PATTERNS)-1:0]   match_id
);

  localparam int unsigned IDX_W      = $clog2(NUM_PATTERNS);
  localparam int unsigned LEN_W      = $clog2(MAX_LEN+1);
  localparam int unsigned HIST_BYTES = MAX_LEN - 1;
  localparam int unsigned WIN_BYTES  = HIST_BYTES + WORD_BYTES;
  localparam int unsigned SEEN_MAX   = MAX_LEN + WORD_BYTES;
  localparam int unsigned SEEN_W     = $clog2(SEEN_MAX+1);

  byte_t [HIST_BYTES-1:0]                         r_hist;
  logic [SEEN_W-1:0]                              r_seen;
  logic [NUM_PATTERNS-1:0][MAX_LEN*BYTE_W-1:0]    r_slot_str;
  logic [NUM_PATTERNS-1:0][LEN_W-1:0]             r_slot_len;
  logic                                           r_match;
  logic [NUM_PATTERNS-1:0]                        r_match_vec;
  logic [IDX_W-1:0]                               r_match_id;
  logic [OUT_DELAY-1:0][WORD_BYTES*BYTE_W-1:0]    r_dly_data;
  logic [OUT_DELAY-1:0]                           r_dly_valid;

  byte_t [WIN_BYTES-1:0]                          w_win_raw;
  byte_t [WIN_BYTES-1:0]                          w_win_cmp;
  logic [NUM_PATTERNS-1:0]                        w_hit;
  logic [IDX_W-1:0]                               w_hit_id;

  // Window index 0 is the oldest history byte; the incoming word fills the top.
  always_comb begin
    w_win_raw = '0;
    for (int unsigned k = 0; k < HIST_BYTES; k++) w_win_raw[k] = r_hist[k];
    for (int unsigned o = 0; o < WORD_BYTES; o++)
      w_win_raw[HIST_BYTES+o] = data_in[(WORD_BYTES-1-o)*BYTE_W +: BYTE_W];
    w_win_cmp = w_win_raw;
    if (nocase) begin
      for (int unsigned k = 0; k < WIN_BYTES; k++) w_win_cmp[k] = fold_byte(w_win_raw[k]);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_hist <= '0;
      r_seen <= '0;
    end else if (clear) begin
      r_hist <= '0;
      r_seen <= '0;
    end else if (data_valid) begin
      for (int unsigned k = 0; k < HIST_BYTES; k++) r_hist[k] <= w_win_raw[k+WORD_BYTES];
      r_seen <= (32'(r_seen) + WORD_BYTES >= SEEN_MAX) ? SEEN_W'(SEEN_MAX)
                                                      : r_seen + SEEN_W'(WORD_BYTES);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_slot_str <= '0;
      r_slot_len <= '0;
    end else if (pat_wr_en) begin
      r_slot_str[pat_wr_idx] <= pat_wr_str;
      r_slot_len[pat_wr_idx] <= (32'(pat_wr_len) > MAX_LEN) ? LEN_W'(MAX_LEN) : pat_wr_len;
    end
  end

  for (genvar p = 0; p < NUM_PATTERNS; p++) begin : g_lane
    pattern_lane #(
      .MAX_LEN    (MAX_LEN),
      .WORD_BYTES (WORD_BYTES),
      .LEN_W      (LEN_W),
      .SEEN_W     (SEEN_W)
    ) u_lane (
      .i_str    (r_slot_str[p]),
      .i_len    (r_slot_len[p]),
      .i_win    (w_win_cmp),
      .i_seen   (r_seen),
      .i_nocase (nocase),
      .o_hit    (w_hit[p])
    );
  end

  always_comb begin
    w_hit_id = '0;
    for (int unsigned p = NUM_PATTERNS; p > 0; p--) begin
      if (w_hit[p-1]) w_hit_id = IDX_W'(p-1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_match     <= 1'b0;
      r_match_vec <= '0;
      r_match_id  <= '0;
    end else if (clear || !data_valid) begin
      r_match     <= 1'b0;
      r_match_vec <= '0;
      r_match_id  <= '0;
    end else begin
      r_match     <= |w_hit;
      r_match_vec <= w_hit;
      r_match_id  <= w_hit_id;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_dly_data  <= '0;
      r_dly_valid <= '0;
    end else begin
      r_dly_data  <= {r_dly_data[OUT_DELAY-2:0], data_in};
      r_dly_valid <= {r_dly_valid[OUT_DELAY-2:0], data_valid};
    end
  end

  assign data_out       = r_dly_data[OUT_DELAY-1];
  assign data_out_valid = r_dly_valid[OUT_DELAY-1];
  assign match          = r_match;
  assign match_vec      = r_match_vec;
  assign match_id       = r_match_id;

endmodule
